apb_req_arbiter: RTL and testbench

- Round-robin arbiter plus APB master that shares one APB bus between NUM_REQ requesters.
- Decodes the upper address bits of each request into a one-hot psel for NUM_SLV apb_mem slaves.
- Sequences the SETUP and ACCESS phases and returns read data with a per-requester done pulse.
- Sits between processing agents and the apb_mem bank. prdata/pready arrive already muxed from the selected slave.

---
 rtl/apb_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter + APB master sharing one bus among NUM_REQ requesters; 3+ cycles per transfer.
// Optional macro APB_TIMEOUT_EN bounds ACCESS to TIMEOUT_CYCLES and completes with rsp_err=1.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_SLV        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                             clk,
    input  logic                                             arst_n,
    input  logic [NUM_REQ-1:0]                               req,
    input  logic [NUM_REQ*($clog2(NUM_SLV)+ADDR_WIDTH)-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                               req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                    req_wdata,
    output logic [NUM_REQ-1:0]                               done,
    output logic [DATA_WIDTH-1:0]                            rsp_rdata,
    output logic                                             rsp_err,
    output logic [NUM_SLV-1:0]                               psel,
    output logic                                             penable,
    output logic [ADDR_WIDTH-1:0]                            paddr,
    output logic                                             pwrite,
    output logic [DATA_WIDTH-1:0]                            pwdata,
    input  logic [DATA_WIDTH-1:0]                            prdata,
    input  logic                                             pready
);

    localparam int SEL_W = $clog2(NUM_SLV);
    localparam int AW    = SEL_W + ADDR_WIDTH;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_win;
    logic [NUM_SLV-1:0]    r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [NUM_REQ-1:0]    r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_gnt;
    logic [PW-1:0]         w_win;
    logic [PW-1:0]         w_ptr_nxt;
    logic [AW-1:0]         w_addr;
    logic                  w_write;
    logic [DATA_WIDTH-1:0] w_wdata;

    // TIMEOUT_CYCLES must be at least 1; this block elaborates to nothing
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_must_be_positive
    end

    // A requester completing this cycle sits out one arbitration round
    assign w_elig = req & ~r_done;

    always_comb begin
        w_gnt = 1'b0;
        w_win = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_gnt = 1'b1;
                w_win = PW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_ptr_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_addr    = req_addr[int'(w_win)*AW +: AW];
    assign w_write   = req_write[w_win];
    assign w_wdata   = req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_state  <= S_SETUP;
                        r_win    <= w_win;
                        r_ptr    <= w_ptr_nxt;
                        r_psel   <= NUM_SLV'(1) << w_addr[AW-1 -: SEL_W];
                        r_paddr  <= w_addr[ADDR_WIDTH-1:0];
                        r_pwrite <= w_write;
                        r_pwdata <= w_wdata;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_state       <= S_IDLE;
                        r_psel        <= '0;
                        r_penable     <= 1'b0;
                        r_done[r_win] <= 1'b1;
                        r_rdata       <= r_pwrite ? '0 : prdata;
                        r_err         <= 1'b0;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state       <= S_IDLE;
                        r_psel        <= '0;
                        r_penable     <= 1'b0;
                        r_done[r_win] <= 1'b1;
                        r_rdata       <= '0;
                        r_err         <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios then random traffic against a transaction-level
// reference model with an APB memory slave per select line.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
    localparam int NR  = 4;
    localparam int NS  = 4;
    localparam int AWD = 8;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int SW  = 2;
    localparam int RAW = SW + AWD;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NR-1:0]     req;
    logic [NR*RAW-1:0] req_addr;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NS-1:0]     psel;
    logic              penable;
    logic [AWD-1:0]    paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;

    logic [RAW-1:0] f_addr [NR];
    logic           f_wr   [NR];
    logic [DW-1:0]  f_wd   [NR];

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_addr[g*RAW +: RAW] = f_addr[g];
        assign req_write[g]           = f_wr[g];
        assign req_wdata[g*DW +: DW]  = f_wd[g];
    end

    always #5 clk = ~clk;

    apb_req_arbiter #(.NUM_REQ(NR), .NUM_SLV(NS), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW),
                      .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .arst_n(arst_n), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready));

    // slave memories (written from observed APB traffic) and requester-view shadow
    logic [DW-1:0] mem    [NS][256];
    logic [DW-1:0] shadow [NS][256];
    int ws_slv [NS];
    int acc_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit keep [NR];
    bit rnd = 0;
    int order_q [$];
    int done_cyc_q [$];
    int done_cnt [NR];
    int sel_len, pen_len, last_sel, last_pen;

    // reference model state
    int            m_ptr, m_win, m_age, m_tcnt, m_slv;
    bit            m_busy;
    logic [NS-1:0] m_psel;
    bit            m_pen, m_pwr, m_err;
    logic [AWD-1:0] m_paddr;
    logic [DW-1:0] m_pwd, m_rdata;
    logic [NR-1:0] m_done;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int oh(logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_grant(int i);
        m_busy  = 1;
        m_win   = i;
        m_age   = 1;
        m_slv   = int'(f_addr[i][RAW-1 -: SW]);
        m_psel  = NS'(1) << m_slv;
        m_pen   = 0;
        m_paddr = f_addr[i][AWD-1:0];
        m_pwr   = f_wr[i];
        m_pwd   = f_wd[i];
        m_ptr   = (i + 1) % NR;
    endtask

    task automatic m_finish(bit err);
        m_busy        = 0;
        m_psel        = '0;
        m_pen         = 0;
        m_done[m_win] = 1'b1;
        m_err         = err;
        if (err) m_rdata = '0;
        else if (m_pwr) begin
            m_rdata = '0;
            shadow[m_slv][m_paddr] = m_pwd;
        end else m_rdata = shadow[m_slv][m_paddr];
    endtask

    task automatic model_step(logic [NR-1:0] r, bit rst_n, bit rdy);
        logic [NR-1:0] prev;
        prev = m_done;
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_psel = '0; m_pen = 0; m_paddr = '0; m_pwr = 0;
            m_pwd = '0; m_done = '0; m_rdata = '0; m_err = 0;
            return;
        end
        m_done = '0;
        if (m_busy) begin
            if (m_age == 1) begin
                m_age = 2; m_pen = 1; m_tcnt = 0;
            end else if (rdy) m_finish(0);
            else begin
                m_tcnt++;
`ifdef APB_TIMEOUT_EN
                if (m_tcnt == TO) m_finish(1);
`endif
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (r[i] && !prev[i]) begin
                    m_grant(i);
                    break;
                end
            end
        end
    endtask

    task automatic set_req(int i, int slv, int a, bit wr, int wd);
        f_addr[i] = RAW'(slv * 256 + a);
        f_wr[i]   = wr;
        f_wd[i]   = DW'(wd);
        req[i]    = 1'b1;
    endtask

    task automatic rand_req(int i);
        set_req(i, $urandom_range(NS - 1), $urandom_range(7), 1'($urandom_range(1)), $urandom_range(255));
    endtask

    task automatic tick();
        logic [NR-1:0]  c_req;
        logic [NS-1:0]  c_psel;
        logic [AWD-1:0] c_paddr;
        logic [DW-1:0]  c_pwd;
        bit c_rst, c_rdy, c_pen, c_pwr;
        c_req = req; c_rst = arst_n; c_rdy = pready;
        c_psel = psel; c_pen = penable; c_pwr = pwrite; c_paddr = paddr; c_pwd = pwdata;
        @(posedge clk);
        #1;
        cyc++;
        if (c_rst && c_psel != 0 && c_pen && c_rdy && c_pwr) mem[oh(c_psel)][c_paddr] = c_pwd;
        model_step(c_req, c_rst, c_rdy);

        chk("psel", psel, m_psel);
        chk("penable", penable, m_pen);
        chk("done", done, m_done);
        if (!c_rst || m_psel != 0) begin
            chk("paddr", paddr, m_paddr);
            chk("pwrite", pwrite, m_pwr);
            chk("pwdata", pwdata, m_pwd);
        end
        if (!c_rst || m_done != 0) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
        end

        if (!c_rst) begin sel_len = 0; pen_len = 0; end
        if (psel != 0) sel_len++;
        if (penable) pen_len++;
        if (psel != 0 && penable) acc_n++; else acc_n = 0;
        pready = (psel != 0) && (acc_n > ws_slv[oh(psel)]);
        prdata = (psel != 0) ? mem[oh(psel)][paddr] : '0;
        if (rnd && psel == 0) for (int s = 0; s < NS; s++) ws_slv[s] = $urandom_range(3);

        for (int i = 0; i < NR; i++) begin
            if (done[i]) begin
                order_q.push_back(i);
                done_cyc_q.push_back(cyc);
                done_cnt[i]++;
                last_sel = sel_len; last_pen = pen_len; sel_len = 0; pen_len = 0;
                if (rnd) begin
                    if ($urandom_range(1) == 1) rand_req(i); else req[i] = 1'b0;
                end else if (!keep[i]) req[i] = 1'b0;
            end else if (rnd) begin
                if (!req[i] && !(m_busy && m_win == i) && $urandom_range(3) == 0) rand_req(i);
                else if (req[i] && m_busy && m_win == i && m_age >= 2 && $urandom_range(15) == 0)
                    req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(int idx, int budget, string tag);
        int n;
        n = 0;
        do begin tick(); n++; end while (!done[idx] && n < budget);
        if (!done[idx]) chk(tag, done[idx], 1);
    endtask

    task automatic do_reset();
        arst_n = 1'b0; tick();
        arst_n = 1'b1; tick();
    endtask

    initial begin
        int c0, n;
        req = '0; pready = 0; prdata = '0; acc_n = 0; arst_n = 1'b0;
        sel_len = 0; pen_len = 0; last_sel = 0; last_pen = 0;
        m_ptr = 0; m_busy = 0; m_done = '0; m_win = 0; m_age = 0; m_tcnt = 0; m_slv = 0;
        for (int i = 0; i < NR; i++) begin
            f_addr[i] = '0; f_wr[i] = 0; f_wd[i] = '0; keep[i] = 0; done_cnt[i] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            ws_slv[s] = 0;
            for (int a = 0; a < 256; a++) begin
                mem[s][a]    = DW'(s * 37 + a * 5 + 3);
                shadow[s][a] = DW'(s * 37 + a * 5 + 3);
            end
        end

        tick(); tick();
        chk("rst_psel", psel, 0);
        chk("rst_done", done, 0);
        arst_n = 1'b1; tick();

        // single write then read-back
        set_req(0, 1, 8'h10, 1, 8'hA5);
        tick(); chk("wr_setup_psel", psel, 4'b0010); chk("wr_setup_pen", penable, 0);
        tick(); chk("wr_access_pen", penable, 1);
        tick(); chk("wr_done", done, 4'b0001); chk("wr_done_psel", psel, 0);
        set_req(0, 1, 8'h10, 0, 0);
        wait_done(0, 20, "rd_wait");
        chk("rd_rdata", rsp_rdata, 8'hA5);

        // contention after reset, then all four held
        do_reset();
        order_q.delete();
        set_req(0, 0, 1, 1, 8'h01);
        set_req(2, 2, 2, 1, 8'h02);
        wait_done(2, 20, "cont_wait");
        chk("cont_n", order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk("cont_first", order_q[0], 0);
            chk("cont_second", order_q[1], 2);
        end
        for (int i = 0; i < NR; i++) begin keep[i] = 1; set_req(i, i, 16 + i, 1, 8'h30 + i); end
        order_q.delete(); done_cyc_q.delete();
        n = 0;
        while (order_q.size() < 5 && n < 40) begin tick(); n++; end
        chk("rr_n", order_q.size() >= 5, 1);
        if (order_q.size() >= 5) begin
            chk("rr_0", order_q[0], 3); chk("rr_1", order_q[1], 0);
            chk("rr_2", order_q[2], 1); chk("rr_3", order_q[3], 2);
            chk("rr_4", order_q[4], 3);
            for (int k = 1; k < 5; k++) chk("rr_spacing", done_cyc_q[k] - done_cyc_q[k-1], 3);
        end
        for (int i = 0; i < NR; i++) begin keep[i] = 0; req[i] = 1'b0; end
        repeat (8) tick();

        // wait states
        ws_slv[2] = 3;
        c0 = done_cnt[1];
        set_req(1, 2, 8'h33, 1, 8'h5C);
        wait_done(1, 20, "ws_wait");
        chk("ws_pen_len", last_pen, 4);
        chk("ws_sel_len", last_sel, 5);
        repeat (6) tick();
        chk("ws_single_done", done_cnt[1] - c0, 1);
        ws_slv[2] = 0;

        // reset during ACCESS
        ws_slv[0] = 5;
        set_req(3, 0, 8'h44, 0, 0);
        n = 0;
        do begin tick(); n++; end while (!penable && n < 10);
        tick();
        chk("mid_in_access", penable, 1);
        arst_n = 1'b0; req[3] = 1'b0; tick();
        chk("mid_rst_psel", psel, 0); chk("mid_rst_pen", penable, 0); chk("mid_rst_done", done, 0);
        arst_n = 1'b1;
        ws_slv[0] = 0;
        set_req(0, 1, 8'h10, 0, 0);
        set_req(1, 2, 8'h33, 0, 0);
        tick();
        chk("post_rst_psel", psel, 4'b0010);
        wait_done(0, 20, "post_rst_w0");
        chk("post_rst_rdata", rsp_rdata, 8'hA5);
        wait_done(1, 20, "post_rst_w1");
        chk("post_rst_rdata1", rsp_rdata, 8'h5C);

        // back-to-back same requester
        repeat (3) tick();
        keep[1] = 1;
        c0 = done_cnt[1];
        set_req(1, 3, 8'h20, 1, 8'h11);
        done_cyc_q.delete();
        wait_done(1, 20, "b2b_first");
        keep[1] = 0;
        wait_done(1, 20, "b2b_second");
        chk("b2b_count", done_cnt[1] - c0, 2);
        if (done_cyc_q.size() == 2) chk("b2b_spacing", done_cyc_q[1] - done_cyc_q[0], 4);
        else chk("b2b_pulses", done_cyc_q.size(), 2);
        repeat (4) tick();

`ifdef APB_TIMEOUT_EN
        do_reset();
        ws_slv[3] = 1000;
        set_req(0, 3, 8'h07, 0, 0);
        set_req(1, 0, 8'h08, 1, 8'h99);
        wait_done(0, 60, "to_wait");
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_len", last_pen, TO);
        wait_done(1, 20, "to_next_wait");
        chk("to_next_err", rsp_err, 0);
        ws_slv[3] = 0;
        repeat (3) tick();
`endif

        // random traffic
        rnd = 1;
        repeat (3000) tick();
        rnd = 0;
        req = '0;
        for (int s = 0; s < NS; s++) ws_slv[s] = 0;
        repeat (20) tick();
        chk("drain_idle", psel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
